// File: rtl/result_tx_sched_pkg.sv
// Shared types and constants for the result readout scheduler.
// State encodings are fixed because they drive the segment display.
package result_tx_sched_pkg;

    localparam int AW = 11;
    localparam int RD_LAT = 2;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_WAIT_RD = 4'd2,
        S_SEND    = 4'd3,
        S_WAIT_TX = 4'd4,
        S_NEXT    = 4'd5,
        S_DONE    = 4'd6
    } state_t;

    function automatic int log2n(input int n);
        int k;
        k = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) k = i + 1;
        return k;
    endfunction

endpackage

// File: rtl/result_tx_sched_word_serializer.sv
// Holds one 32-bit result word and hands it to the UART MSB byte first.
// A byte is retired only by a tx_done seen while waiting on the UART.
module result_tx_sched_word_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word_in,
    input  logic        send_phase,
    input  logic        wait_phase,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        send,
    output logic        byte_done,
    output logic        last_byte_done
);

    logic [31:0] sr;
    logic [1:0]  b;

    assign tx_data = sr[31:24];
    assign send = send_phase;
    assign byte_done = wait_phase && tx_done;
    assign last_byte_done = byte_done && (b == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            b  <= '0;
        end else if (load) begin
            sr <= word_in;
            b  <= '0;
        end else if (byte_done && (b != 2'd3)) begin
            sr <= sr << 8;
            b  <= b + 2'd1;
        end
    end

endmodule

// File: rtl/result_tx_sched.sv
// Walks result matrix C row-major, reads the owning PE RAM and
// streams each 32-bit element over the shared UART as 4 bytes.
module result_tx_sched
    import result_tx_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [7:0]                   res_h,
    input  logic [7:0]                   res_w,
    output logic [N-1:0][N-1:0][AW-1:0] ram_c_addr,
    input  logic [N-1:0][N-1:0][31:0]   ram_c_q,
    output logic [7:0]                   uart_tx_data,
    output logic                         uart_send_data,
    input  logic                         uart_tx_done,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   state_val
);

    localparam int L = (N > 1) ? log2n(N) : 1;

    state_t        state, state_n;
    logic [7:0]    r, c, h, w, tw;
    logic [7:0]    nr, nc, tw_new;
    logic [3:0]    cnt;
    logic [AW-1:0] addr;
    logic [31:0]   q_sel;
    logic          load, byte_done, last_done;
    logic          dims_ok;

    function automatic logic [AW-1:0] addr_of(
        input logic [7:0] rr,
        input logic [7:0] cc,
        input logic [7:0] tww
    );
        return AW'(16'(rr >> L) * 16'(tww) + 16'(cc >> L));
    endfunction

    assign dims_ok = (res_h != 8'd0) && (res_w != 8'd0);
    assign tw_new = (res_w >> L) + 8'(|res_w[L-1:0]);
    assign q_sel = ram_c_q[r[L-1:0]][c[L-1:0]];
    assign ram_c_addr = {(N*N){addr}};
    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign state_val = state;

    always_comb begin
        state_n = state;
        load = 1'b0;
        nr = r;
        nc = c;
        if (c < w - 8'd1) begin
            nc = c + 8'd1;
        end else begin
            nc = 8'd0;
            nr = r + 8'd1;
        end
        unique case (state)
            S_IDLE:
                if (start) state_n = dims_ok ? S_ADDR : S_DONE;
            S_ADDR:
                state_n = S_WAIT_RD;
            S_WAIT_RD:
                if (cnt == 4'd0) begin
                    load = 1'b1;
                    state_n = S_SEND;
                end
            S_SEND:
                state_n = S_WAIT_TX;
            S_WAIT_TX:
                if (last_done) state_n = S_NEXT;
                else if (byte_done) state_n = S_SEND;
            S_NEXT:
                if (r == h - 8'd1 && c == w - 8'd1) state_n = S_DONE;
                else state_n = S_ADDR;
            S_DONE:
                state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    // Address is registered on entry to ADDR so q lands RD_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
            h     <= '0;
            w     <= '0;
            tw    <= '0;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE:
                    if (start && dims_ok) begin
                        h    <= res_h;
                        w    <= res_w;
                        tw   <= tw_new;
                        r    <= '0;
                        c    <= '0;
                        addr <= '0;
                    end
                S_ADDR:
                    cnt <= 4'(RD_LAT - 1);
                S_WAIT_RD:
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                S_NEXT:
                    if (state_n == S_ADDR) begin
                        r    <= nr;
                        c    <= nc;
                        addr <= addr_of(nr, nc, tw);
                    end
                default: ;
            endcase
        end
    end

    result_tx_sched_word_serializer u_ser (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .word_in        (q_sel),
        .send_phase     (state == S_SEND),
        .wait_phase     (state == S_WAIT_TX),
        .tx_done        (uart_tx_done),
        .tx_data        (uart_tx_data),
        .send           (uart_send_data),
        .byte_done      (byte_done),
        .last_byte_done (last_done)
    );

endmodule

// File: tb/tb_result_tx_sched.sv
// Randomized bench for result_tx_sched with a RAM/UART model and
// a row-major reference stream built from the element mapping rules.
module tb_result_tx_sched;
    import result_tx_sched_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start;
    logic [7:0] res_h, res_w;
    logic [N-1:0][N-1:0][AW-1:0] ram_c_addr;
    logic [N-1:0][N-1:0][31:0] ram_c_q, st1;
    logic [7:0] uart_tx_data;
    logic uart_send_data, uart_tx_done, busy, done;
    logic [3:0] state_val;
    logic tx_u, spur;

    assign uart_tx_done = tx_u | spur;

    result_tx_sched #(.N(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .res_h          (res_h),
        .res_w          (res_w),
        .ram_c_addr     (ram_c_addr),
        .ram_c_q        (ram_c_q),
        .uart_tx_data   (uart_tx_data),
        .uart_send_data (uart_send_data),
        .uart_tx_done   (uart_tx_done),
        .busy           (busy),
        .done           (done),
        .state_val      (state_val)
    );

    logic [31:0] mem [N][N][2048];
    logic [7:0] got[$], eb[$];
    logic [AW-1:0] gaddr[$], ea[$];
    int n_cmp = 0, n_err = 0;
    int stable_err = 0, extra_send = 0, addr_split = 0;
    int max_dly = 50;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // RAM model: RD_LAT-cycle pipeline per PE
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                st1[i][j] <= mem[i][j][ram_c_addr[i][j]];
                ram_c_q[i][j] <= st1[i][j];
            end
    end

    // UART model: records each byte, answers after a random delay
    initial begin
        int d;
        logic [7:0] bt;
        tx_u = 1'b0;
        forever begin
            @(negedge clk);
            while (rst_n && uart_send_data) begin
                bt = uart_tx_data;
                got.push_back(bt);
                gaddr.push_back(ram_c_addr[0][0]);
                if (ram_c_addr !== {(N*N){ram_c_addr[0][0]}})
                    addr_split++;
                d = $urandom_range(max_dly, 1);
                repeat (d) begin
                    @(negedge clk);
                    if (rst_n && uart_send_data) extra_send++;
                    if (rst_n && uart_tx_data !== bt) stable_err++;
                end
                tx_u = 1'b1;
                @(negedge clk);
                tx_u = 1'b0;
            end
        end
    end

    // Spurious tx_done while addressing or on the send cycle itself
    initial begin
        spur = 1'b0;
        forever begin
            @(negedge clk);
            spur = rst_n && (state_val == 4'd1 || state_val == 4'd3)
                   && ($urandom_range(1, 0) == 1);
        end
    end

    task automatic fill();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int a = 0; a < 256; a++)
                    mem[i][j][a] = $urandom;
    endtask

    task automatic build_exp(input int h, input int w);
        int tw, a;
        logic [31:0] wd;
        eb.delete();
        ea.delete();
        tw = (w + N - 1) / N;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                a = ((r / N) * tw + c / N) % (1 << AW);
                wd = mem[r % N][c % N][a];
                for (int k = 0; k < 4; k++) begin
                    eb.push_back(8'(wd >> (24 - 8 * k)));
                    ea.push_back(AW'(a));
                end
            end
    endtask

    task automatic run(input string nm, input int h, input int w,
                       input int second_at, output int lat,
                       output int done_at, output int bcnt);
        int cyc, dn;
        bit fired;
        got.delete();
        gaddr.delete();
        stable_err = 0;
        extra_send = 0;
        addr_split = 0;
        lat = -1;
        done_at = -1;
        bcnt = 0;
        dn = 0;
        fired = 0;
        @(negedge clk);
        res_h = 8'(h);
        res_w = 8'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res_h = 8'($urandom);
        res_w = 8'($urandom);
        cyc = 1;
        while (done_at < 0 && cyc < 20000) begin
            if (uart_send_data && lat < 0) lat = cyc;
            if (busy) bcnt++;
            if (done) begin
                done_at = cyc;
                dn++;
            end
            start = 1'b0;
            if (second_at >= 0 && !fired && got.size() >= second_at) begin
                start = 1'b1;
                res_h = 8'd2;
                res_w = 8'd2;
                fired = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({nm, " done_seen"}, done_at >= 0, 1);
        repeat (3) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk({nm, " done_pulses"}, dn, 1);
        chk({nm, " busy_after"}, busy, 0);
        chk({nm, " tx_hold"}, stable_err, 0);
        chk({nm, " extra_send"}, extra_send, 0);
        chk({nm, " addr_bcast"}, addr_split, 0);
        build_exp(h, w);
        chk({nm, " nbytes"}, got.size(), eb.size());
        for (int k = 0; k < eb.size() && k < got.size(); k++) begin
            chk($sformatf("%s byte%0d", nm, k), got[k], eb[k]);
            chk($sformatf("%s addr%0d", nm, k), gaddr[k], ea[k]);
        end
    endtask

    initial begin
        int lat, da, bc, t, dn, h, w;
        rst_n = 1'b0;
        start = 1'b0;
        res_h = '0;
        res_w = '0;
        fill();
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst send", uart_send_data, 0);
        chk("rst state", state_val, 0);
        chk("rst txdata", uart_tx_data, 0);
        chk("rst addr", ram_c_addr == '0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle state", state_val, 0);

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mem[i][j][0] = 32'h3F80_0000 + 32'(i * 4 + j);
        run("4x4", 4, 4, 10, lat, da, bc);
        chk("4x4 latency", lat, RD_LAT + 2);
        chk("4x4 b0", got.size() > 3 ? got[0] : 8'hxx, 8'h3F);
        chk("4x4 b1", got.size() > 3 ? got[1] : 8'hxx, 8'h80);
        chk("4x4 b2", got.size() > 3 ? got[2] : 8'hxx, 8'h00);
        chk("4x4 b3", got.size() > 3 ? got[3] : 8'hxx, 8'h00);

        fill();
        mem[1][2][1] = 32'hDEAD_BEEF;
        run("8x4", 8, 4, -1, lat, da, bc);
        chk("8x4 e52 b0", got.size() > 91 ? got[88] : 8'hxx, 8'hDE);
        chk("8x4 e52 b1", got.size() > 91 ? got[89] : 8'hxx, 8'hAD);
        chk("8x4 e52 b2", got.size() > 91 ? got[90] : 8'hxx, 8'hBE);
        chk("8x4 e52 b3", got.size() > 91 ? got[91] : 8'hxx, 8'hEF);
        chk("8x4 e52 addr", got.size() > 91 ? gaddr[88] : 'x, 1);

        run("h0", 0, 4, -1, lat, da, bc);
        chk("h0 done_at", da, 1);
        chk("h0 busy_cyc", bc <= 1, 1);
        chk("h0 sends", got.size(), 0);
        run("w0", 3, 0, -1, lat, da, bc);
        chk("w0 done_at", da, 1);

        max_dly = 6;
        for (int n = 0; n < 3; n++) begin
            fill();
            h = $urandom_range(6, 1);
            w = $urandom_range(6, 1);
            run($sformatf("rnd%0d_%0dx%0d", n, h, w), h, w, -1, lat, da, bc);
        end

        max_dly = 20;
        got.delete();
        @(negedge clk);
        res_h = 8'd4;
        res_w = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (got.size() < 6 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        while (state_val != 4'd4 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid reached", t < 5000, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid busy", busy, 0);
        chk("rst_mid done", done, 0);
        chk("rst_mid send", uart_send_data, 0);
        chk("rst_mid state", state_val, 0);
        chk("rst_mid txdata", uart_tx_data, 0);
        chk("rst_mid addr", ram_c_addr == '0, 1);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_mid no_done", dn, 0);
        run("replay", 4, 4, -1, lat, da, bc);
        chk("replay latency", lat, RD_LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_tx_sched.md
Name: result_tx_sched

Overview:
- Sequences readout of the result matrix C, which is held in the N×N per-PE result RAMs, after the array signals calc_done.
- Walks the elements in row-major order and broadcasts one read address to all PE RAMs.
- Selects the owning PE's 32-bit word and serializes it as 4 bytes, MSB first, over the shared UART transmitter using a send/done handshake.
- Sits between the PE array result RAMs and the UART TX, alongside the top-level load FSM.

Parameters:
N, `N (param.vh, default 4), PE array dimension; must be a power of 2.
RD_LAT, 2, RAM read latency in cycles from address to valid q.
AW, 11, result RAM address width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse (from calc_done edge) that begins readout
res_h  in  8  result rows; sampled on accepted start
res_w  in  8  result columns; sampled on accepted start
ram_c_addr  out  [N-1:0][N-1:0][AW]  read address to every PE result RAM
ram_c_q  in  [N-1:0][N-1:0][32]  PE result RAM read data
uart_tx_data  out  8  byte to transmit
uart_send_data  out  1  one-cycle send strobe to UART TX
uart_tx_done  in  1  one-cycle pulse when the UART finishes the current byte
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after the last byte completes
state_val  out  4  state encoding for the seg display

Behaviour:
- Reset:
  - all outputs 0; state IDLE; counters 0.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- Element mapping:
  - Element (r,c) is owned by PE (r mod N, c mod N).
  - Its address is (r>>log2N)*tw + (c>>log2N), where tw = ceil(res_w/N), computed once at start.
  - The same address is driven on all N×N ram_c_addr entries.
- States (state_val encoding in brackets):
  - IDLE [0]: on start with res_h≠0 and res_w≠0, latch dims, r=c=0, busy=1, go to ADDR. If either dim is 0, pulse done the next cycle with no UART activity, then IDLE. start while busy is ignored.
  - ADDR [1]: drive the address; load the wait counter with RD_LAT-1; go to WAIT_RD.
  - WAIT_RD [2]: count down; at 0 capture ram_c_q[r mod N][c mod N] into a 32-bit shift register, byte index b=0, go to SEND.
  - SEND [3]: uart_tx_data = word[31-8b -: 8]; uart_send_data=1 for exactly this cycle; go to WAIT_TX.
  - WAIT_TX [4]: hold uart_tx_data stable. On uart_tx_done: if b<3 then b++ and go to SEND; else go to NEXT.
  - NEXT [5]: if c<res_w-1 then c++; else c=0 and r++. If the last element (r=res_h-1, c=res_w-1) is finished, go to DONE; otherwise go to ADDR.
  - DONE [6]: done=1 for one cycle; busy=0; go to IDLE.
- Handshakes:
  - uart_tx_done outside WAIT_TX is ignored.
  - uart_tx_done in the same cycle as uart_send_data is not counted.
  - No timeout; WAIT_TX stalls indefinitely.
- Latency and output volume:
  - start to the first uart_send_data = RD_LAT+2 cycles.
  - Each element adds RD_LAT+3 cycles of overhead beyond UART time.
  - Total bytes sent = 4*res_h*res_w.
- Width rules:
  - r,c are 8-bit. tw is 8-bit.
  - Address product is computed at 16-bit and truncated to AW. Dims exceeding the RAM depth are a caller error; the address wraps silently.
  - ram_c_addr is registered.

Decomposition:
- Shared package: state enum (IDLE..DONE with fixed 4-bit encodings), AW, and a function for log2N. N is taken from param.vh.
- One natural sub-module: word_serializer. It holds the 32-bit load, MSB-first byte shift, and send/done handshake with byte counter, and reports last_byte_done to the scheduler.

Test Plan:
- N=4, res 4×4, PE(i,j) addr0 = 0x3F800000+i*4+j; start → 64 bytes in row-major order; first bytes 3F,80,00,00; done pulses once; busy low afterwards.
- res 8×4 (tw=1): element (5,2) → PE(1,2) addr 1; check the broadcast address equals 1 at that step and bytes match the preloaded value 0xDEADBEEF → DE,AD,BE,EF.
- res_h=0 with res_w=4, start → done one cycle later, zero uart_send_data pulses, busy high at most 1 cycle.
- UART model delays tx_done by random 1–50 cycles, plus spurious tx_done pulses while in ADDR → byte stream unchanged; exactly one send per byte.
- Second start while busy (after byte 10) → ignored; total stays 64 bytes and dims are not re-sampled.
- rst_n asserted asynchronously mid-byte → all outputs 0 immediately, no done pulse; a subsequent start replays from element (0,0).
